// File: rtl/directory_req_sched_pkg.sv
// Shared defaults and small helpers for the directory bank request front-end.
// Imported by the interface, the queue sub-module and the top level.
package directory_req_sched_pkg;

    localparam int DR_PADDR_W  = 50;
    localparam int DR_CMD_W    = 3;
    localparam int DR_DRID_W   = 6;
    localparam int DR_REQ_DEPTH = 4;
    localparam int DR_PF_DEPTH  = 8;
    localparam int DR_MAX_OUT   = 8;
    localparam int DR_CNT_W     = 16;

    // Number of prefetch drop events in one cycle (overflow plus filter).
    function automatic logic [1:0] drop_events(input logic overflow, input logic filtered);
        return {1'b0, overflow} + {1'b0, filtered};
    endfunction

endpackage

// File: rtl/directory_req_sched_if.sv
// Bundles the L2-side, memory-side and ack channels of the directory request scheduler.
// slave is the scheduler's view; master is the environment's view.
interface directory_req_sched_if
    import directory_req_sched_pkg::*;
#(
    parameter int PADDR_W = DR_PADDR_W,
    parameter int CMD_W   = DR_CMD_W,
    parameter int DRID_W  = DR_DRID_W
);
    logic               l2todr_req_valid;
    logic               l2todr_req_retry;
    logic [PADDR_W-1:0] l2todr_req_paddr;
    logic [CMD_W-1:0]   l2todr_req_cmd;

    logic               l2todr_pfreq_valid;
    logic               l2todr_pfreq_retry;
    logic [PADDR_W-1:0] l2todr_pfreq_paddr;

    logic               drtomem_req_valid;
    logic               drtomem_req_retry;
    logic [PADDR_W-1:0] drtomem_req_paddr;
    logic [CMD_W-1:0]   drtomem_req_cmd;
    logic [DRID_W-1:0]  drtomem_req_drid;

    logic               drtomem_pfreq_valid;
    logic               drtomem_pfreq_retry;
    logic [PADDR_W-1:0] drtomem_pfreq_paddr;

    logic               memtodr_ack_valid;
    logic               memtodr_ack_retry;
    logic [DRID_W-1:0]  memtodr_ack_drid;

    modport slave (
        input  l2todr_req_valid, l2todr_req_paddr, l2todr_req_cmd,
        output l2todr_req_retry,
        input  l2todr_pfreq_valid, l2todr_pfreq_paddr,
        output l2todr_pfreq_retry,
        output drtomem_req_valid, drtomem_req_paddr, drtomem_req_cmd, drtomem_req_drid,
        input  drtomem_req_retry,
        output drtomem_pfreq_valid, drtomem_pfreq_paddr,
        input  drtomem_pfreq_retry,
        input  memtodr_ack_valid, memtodr_ack_drid,
        output memtodr_ack_retry
    );

    modport master (
        output l2todr_req_valid, l2todr_req_paddr, l2todr_req_cmd,
        input  l2todr_req_retry,
        output l2todr_pfreq_valid, l2todr_pfreq_paddr,
        input  l2todr_pfreq_retry,
        input  drtomem_req_valid, drtomem_req_paddr, drtomem_req_cmd, drtomem_req_drid,
        output drtomem_req_retry,
        input  drtomem_pfreq_valid, drtomem_pfreq_paddr,
        output drtomem_pfreq_retry,
        output memtodr_ack_valid, memtodr_ack_drid,
        input  memtodr_ack_retry
    );

endinterface

// File: rtl/directory_req_sched_fifo.sv
// Power-of-two circular FIFO. With DROP_OLDEST set, a push into a full queue
// without a same-cycle pop overwrites the oldest entry and pulses o_drop.
module directory_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit DROP_OLDEST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;
    logic w_overwrite;

    assign o_full      = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign w_do_pop    = i_pop && !o_empty;
    assign w_do_push   = i_push && (!o_full || w_do_pop || DROP_OLDEST);
    assign w_overwrite = w_do_push && o_full && !w_do_pop;
    assign o_drop      = w_overwrite;
    assign o_data      = r_mem[r_rd_ptr];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop && !w_overwrite) r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/directory_req_sched.sv
// Directory bank request front-end: demand queue issuing tagged requests from a
// bounded outstanding table, plus a lossy prefetch queue filtered against live lines.
module directory_req_sched
    import directory_req_sched_pkg::*;
#(
    parameter int PADDR_W   = DR_PADDR_W,
    parameter int CMD_W     = DR_CMD_W,
    parameter int DRID_W    = DR_DRID_W,
    parameter int REQ_DEPTH = DR_REQ_DEPTH,
    parameter int PF_DEPTH  = DR_PF_DEPTH,
    parameter int MAX_OUT   = DR_MAX_OUT,
    parameter int CNT_W     = DR_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    directory_req_sched_if.slave         bus,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic [CNT_W-1:0]             pf_drop_cnt,
    output logic                         ack_err
);
    localparam int IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int DQ_W  = PADDR_W + CMD_W;

    logic             w_dq_full, w_dq_empty, w_dq_drop, w_dq_push, w_dq_pop;
    logic [DQ_W-1:0]  w_dq_head;
    logic             w_pfq_full, w_pfq_empty, w_pfq_drop, w_pf_pop;
    logic [PADDR_W-1:0] w_pfq_head;

    logic [MAX_OUT-1:0] r_live;
    logic [PADDR_W-1:0] r_tbl_paddr [MAX_OUT];
    logic [OUT_W-1:0]   r_outstanding;
    logic               r_ack_err;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               r_req_valid;
    logic [PADDR_W-1:0] r_req_paddr;
    logic [CMD_W-1:0]   r_req_cmd;
    logic [DRID_W-1:0]  r_req_drid;
    logic               r_pf_valid;
    logic [PADDR_W-1:0] r_pf_paddr;

    logic [IDX_W-1:0] w_free_idx;
    logic             w_has_free;
    logic             w_req_xfer, w_pf_xfer, w_pf_hit, w_pf_filt;
    logic [IDX_W-1:0] w_ack_idx;
    logic             w_ack_ok, w_ack_bad;
    logic [CNT_W:0]   w_drop_sum;
    logic [CNT_W-1:0] w_drop_next;
    logic             w_unused;

    assign w_dq_push = bus.l2todr_req_valid && !w_dq_full;

    directory_fifo #(.WIDTH(DQ_W), .DEPTH(REQ_DEPTH), .DROP_OLDEST(1'b0)) u_req_q (
        .clk(clk), .reset(reset),
        .i_push(w_dq_push), .i_data({bus.l2todr_req_paddr, bus.l2todr_req_cmd}),
        .i_pop(w_dq_pop), .o_data(w_dq_head),
        .o_empty(w_dq_empty), .o_full(w_dq_full), .o_drop(w_dq_drop)
    );

    directory_fifo #(.WIDTH(PADDR_W), .DEPTH(PF_DEPTH), .DROP_OLDEST(1'b1)) u_pf_q (
        .clk(clk), .reset(reset),
        .i_push(bus.l2todr_pfreq_valid), .i_data(bus.l2todr_pfreq_paddr),
        .i_pop(w_pf_pop), .o_data(w_pfq_head),
        .o_empty(w_pfq_empty), .o_full(w_pfq_full), .o_drop(w_pfq_drop)
    );

    // NOTE: defaults come first so the comb block never infers a latch.
    always_comb begin
        w_free_idx = '0;
        w_has_free = 1'b0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!r_live[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_req_xfer = r_req_valid && !bus.drtomem_req_retry;
    assign w_dq_pop   = (!r_req_valid || w_req_xfer) && !w_dq_empty && w_has_free;

    // Out-of-range or already-free tags only raise the sticky error.
    assign w_ack_idx = bus.memtodr_ack_drid[IDX_W-1:0];
    assign w_ack_ok  = bus.memtodr_ack_valid && (int'(bus.memtodr_ack_drid) < MAX_OUT)
                       && r_live[w_ack_idx];
    assign w_ack_bad = bus.memtodr_ack_valid && !w_ack_ok;

    always_comb begin
        w_pf_hit = r_req_valid && (r_req_paddr == w_pfq_head);
        for (int i = 0; i < MAX_OUT; i++) begin
            if (r_live[i] && (r_tbl_paddr[i] == w_pfq_head)) w_pf_hit = 1'b1;
        end
    end

    assign w_pf_xfer  = r_pf_valid && !bus.drtomem_pfreq_retry;
    assign w_pf_pop   = !w_pfq_empty && (!r_pf_valid || w_pf_xfer);
    assign w_pf_filt  = w_pf_pop && w_pf_hit;
    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(drop_events(w_pfq_drop, w_pf_filt));
    assign w_drop_next = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live        <= '0;
            r_outstanding <= '0;
            r_ack_err     <= 1'b0;
            r_drop_cnt    <= '0;
            r_req_valid   <= 1'b0;
            r_req_paddr   <= '0;
            r_req_cmd     <= '0;
            r_req_drid    <= '0;
            r_pf_valid    <= 1'b0;
            r_pf_paddr    <= '0;
        end else begin
            if (w_ack_ok) r_live[w_ack_idx] <= 1'b0;
            if (w_dq_pop) begin
                r_live[w_free_idx] <= 1'b1;
                r_req_valid        <= 1'b1;
                r_req_paddr        <= w_dq_head[DQ_W-1:CMD_W];
                r_req_cmd          <= w_dq_head[CMD_W-1:0];
                r_req_drid         <= DRID_W'(w_free_idx);
            end else if (w_req_xfer) begin
                r_req_valid <= 1'b0;
            end
            case ({w_dq_pop, w_ack_ok})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_ack_bad) r_ack_err <= 1'b1;
            if (w_pf_pop && !w_pf_hit) begin
                r_pf_valid <= 1'b1;
                r_pf_paddr <= w_pfq_head;
            end else if (w_pf_xfer) begin
                r_pf_valid <= 1'b0;
            end
            r_drop_cnt <= w_drop_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_dq_pop) r_tbl_paddr[w_free_idx] <= w_dq_head[DQ_W-1:CMD_W];
    end

    assign bus.l2todr_req_retry    = w_dq_full;
    assign bus.l2todr_pfreq_retry  = 1'b0;
    assign bus.memtodr_ack_retry   = 1'b0;
    assign bus.drtomem_req_valid   = r_req_valid;
    assign bus.drtomem_req_paddr   = r_req_paddr;
    assign bus.drtomem_req_cmd     = r_req_cmd;
    assign bus.drtomem_req_drid    = r_req_drid;
    assign bus.drtomem_pfreq_valid = r_pf_valid;
    assign bus.drtomem_pfreq_paddr = r_pf_paddr;
    assign outstanding             = r_outstanding;
    assign pf_drop_cnt             = r_drop_cnt;
    assign ack_err                 = r_ack_err;

    assign w_unused = &{1'b0, w_pfq_full, w_dq_drop};

endmodule

// File: tb/tb_directory_req_sched.sv
// Directed bench for directory_req_sched: demand tagging, table-full stall,
// back-pressure, prefetch overflow and filtering, ack errors and async reset.
module tb_directory_req_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  outstanding;
    logic [15:0] pf_drop_cnt;
    logic        ack_err;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [49:0] mq_paddr[$];
    logic [5:0]  mq_drid[$];
    logic [2:0]  mq_cmd[$];
    logic [49:0] pq_paddr[$];

    directory_req_sched_if #(.PADDR_W(50), .CMD_W(3), .DRID_W(6)) dr_if ();

    directory_req_sched dut (
        .clk(clk), .reset(reset), .bus(dr_if),
        .outstanding(outstanding), .pf_drop_cnt(pf_drop_cnt), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Records completed transfers; sampled mid-cycle where inputs and outputs are stable.
    always @(negedge clk) begin
        if (!reset && dr_if.drtomem_req_valid && !dr_if.drtomem_req_retry) begin
            mq_paddr.push_back(dr_if.drtomem_req_paddr);
            mq_drid.push_back(dr_if.drtomem_req_drid);
            mq_cmd.push_back(dr_if.drtomem_req_cmd);
        end
        if (!reset && dr_if.drtomem_pfreq_valid && !dr_if.drtomem_pfreq_retry)
            pq_paddr.push_back(dr_if.drtomem_pfreq_paddr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dem(input logic [49:0] a, input logic [2:0] c);
        int guard = 0;
        dr_if.l2todr_req_valid = 1'b1;
        dr_if.l2todr_req_paddr = a;
        dr_if.l2todr_req_cmd   = c;
        while (dr_if.l2todr_req_retry && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("push_dem_timeout", 64'(guard), 64'd0);
        tick();
        dr_if.l2todr_req_valid = 1'b0;
    endtask

    task automatic push_pf(input logic [49:0] a);
        dr_if.l2todr_pfreq_valid = 1'b1;
        dr_if.l2todr_pfreq_paddr = a;
        tick();
        dr_if.l2todr_pfreq_valid = 1'b0;
    endtask

    task automatic send_ack(input logic [5:0] d);
        dr_if.memtodr_ack_valid = 1'b1;
        dr_if.memtodr_ack_drid  = d;
        tick();
        dr_if.memtodr_ack_valid = 1'b0;
    endtask

    task automatic wait_mq(input string tag, input int n, input int budget);
        int k = 0;
        while (mq_paddr.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(mq_paddr.size()), 64'(n));
    endtask

    task automatic wait_pq(input string tag, input int n, input int budget);
        int k = 0;
        while (pq_paddr.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 64'(pq_paddr.size()), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int pbase;
        int acc;
        dr_if.l2todr_req_valid    = 1'b0;
        dr_if.l2todr_req_paddr    = '0;
        dr_if.l2todr_req_cmd      = '0;
        dr_if.l2todr_pfreq_valid  = 1'b0;
        dr_if.l2todr_pfreq_paddr  = '0;
        dr_if.drtomem_req_retry   = 1'b0;
        dr_if.drtomem_pfreq_retry = 1'b0;
        dr_if.memtodr_ack_valid   = 1'b0;
        dr_if.memtodr_ack_drid    = '0;

        repeat (2) tick();
        check("rst_req_valid", 64'(dr_if.drtomem_req_valid), 64'd0);
        check("rst_pf_valid", 64'(dr_if.drtomem_pfreq_valid), 64'd0);
        check("rst_l2_retry", 64'(dr_if.l2todr_req_retry), 64'd0);
        check("rst_pf_retry", 64'(dr_if.l2todr_pfreq_retry), 64'd0);
        check("rst_ack_retry", 64'(dr_if.memtodr_ack_retry), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_drop_cnt", 64'(pf_drop_cnt), 64'd0);
        check("rst_ack_err", 64'(ack_err), 64'd0);
        check("rst_req_paddr", 64'(dr_if.drtomem_req_paddr), 64'd0);
        reset = 1'b0;
        tick();

        // Single demand: two-cycle latency, drid 0, ack retires it.
        push_dem(50'h100, 3'd1);
        check("t1_not_yet", 64'(dr_if.drtomem_req_valid), 64'd0);
        tick();
        check("t1_valid", 64'(dr_if.drtomem_req_valid), 64'd1);
        check("t1_drid", 64'(dr_if.drtomem_req_drid), 64'd0);
        check("t1_paddr", 64'(dr_if.drtomem_req_paddr), 64'h100);
        check("t1_cmd", 64'(dr_if.drtomem_req_cmd), 64'd1);
        check("t1_outstanding", 64'(outstanding), 64'd1);
        tick();
        check("t1_valid_drop", 64'(dr_if.drtomem_req_valid), 64'd0);
        send_ack(6'd0);
        check("t1_ack_out", 64'(outstanding), 64'd0);
        check("t1_ack_err", 64'(ack_err), 64'd0);

        // Nine demands, no acks: drids 0..7 then the ninth stalls until drid 3 frees.
        base = mq_paddr.size();
        for (int i = 0; i < 9; i++) push_dem(50'h1000 + 50'(i * 'h40), 3'(i));
        wait_mq("t2_eight_issued", base + 8, 20);
        repeat (3) tick();
        check("t2_ninth_held", 64'(mq_paddr.size()), 64'(base + 8));
        check("t2_held_valid", 64'(dr_if.drtomem_req_valid), 64'd0);
        check("t2_outstanding", 64'(outstanding), 64'd8);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("t2_drid%0d", j), 64'(mq_drid[base + j]), 64'(j));
            check($sformatf("t2_addr%0d", j), 64'(mq_paddr[base + j]), 64'h1000 + 64'(j * 'h40));
        end
        send_ack(6'd3);
        wait_mq("t2_ninth_issued", base + 9, 5);
        check("t2_ninth_drid", 64'(mq_drid[base + 8]), 64'd3);
        check("t2_ninth_addr", 64'(mq_paddr[base + 8]), 64'h1200);
        check("t2_ninth_cmd", 64'(mq_cmd[base + 8]), 64'd0);
        check("t2_out_refill", 64'(outstanding), 64'd8);
        for (int d = 0; d < 8; d++) send_ack(6'(d));
        check("t2_drained", 64'(outstanding), 64'd0);
        check("t2_ack_err", 64'(ack_err), 64'd0);

        // Memory back-pressure: five accepts before retry, payload held, nothing lost.
        base = mq_paddr.size();
        dr_if.drtomem_req_retry = 1'b1;
        acc = 0;
        dr_if.l2todr_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (dr_if.l2todr_req_retry) break;
            dr_if.l2todr_req_paddr = 50'h2000 + 50'(acc * 'h40);
            dr_if.l2todr_req_cmd   = 3'(acc);
            tick();
            acc++;
        end
        dr_if.l2todr_req_valid = 1'b0;
        check("t3_accepts", 64'(acc), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", 64'(dr_if.drtomem_req_valid), 64'd1);
            check("t3_hold_paddr", 64'(dr_if.drtomem_req_paddr), 64'h2000);
            check("t3_hold_retry", 64'(dr_if.l2todr_req_retry), 64'd1);
            tick();
        end
        dr_if.drtomem_req_retry = 1'b0;
        wait_mq("t3_released", base + 5, 20);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("t3_addr%0d", j), 64'(mq_paddr[base + j]), 64'h2000 + 64'(j * 'h40));
            check($sformatf("t3_drid%0d", j), 64'(mq_drid[base + j]), 64'(j));
        end
        check("t3_retry_low", 64'(dr_if.l2todr_req_retry), 64'd0);
        for (int d = 0; d < 5; d++) send_ack(6'(d));
        check("t3_drained", 64'(outstanding), 64'd0);

        // Prefetch overflow: 10 pushes, one held in the register, eight queued, one dropped.
        pbase = pq_paddr.size();
        dr_if.drtomem_pfreq_retry = 1'b1;
        for (int i = 0; i < 10; i++) push_pf(50'h3000 + 50'(i * 'h40));
        check("t4_drop_cnt", 64'(pf_drop_cnt), 64'd1);
        check("t4_pf_held", 64'(dr_if.drtomem_pfreq_paddr), 64'h3000);
        check("t4_pf_l2_retry", 64'(dr_if.l2todr_pfreq_retry), 64'd0);
        dr_if.drtomem_pfreq_retry = 1'b0;
        wait_pq("t4_released", pbase + 9, 30);
        check("t4_pf0", 64'(pq_paddr[pbase]), 64'h3000);
        for (int j = 1; j < 9; j++)
            check($sformatf("t4_pf%0d", j), 64'(pq_paddr[pbase + j]), 64'h3000 + 64'((j + 1) * 'h40));
        repeat (3) tick();
        check("t4_no_dup", 64'(pq_paddr.size()), 64'(pbase + 9));

        // Filter: prefetch to a live demand line is discarded.
        base = mq_paddr.size();
        push_dem(50'h200, 3'd2);
        wait_mq("t5_dem_issued", base + 1, 10);
        check("t5_outstanding", 64'(outstanding), 64'd1);
        pbase = pq_paddr.size();
        push_pf(50'h200);
        push_pf(50'h204);
        wait_pq("t5_pf_issued", pbase + 1, 10);
        repeat (3) tick();
        check("t5_only_one", 64'(pq_paddr.size()), 64'(pbase + 1));
        check("t5_pf_addr", 64'(pq_paddr[pbase]), 64'h204);
        check("t5_drop_cnt", 64'(pf_drop_cnt), 64'd2);
        send_ack(mq_drid[base]);
        check("t5_drained", 64'(outstanding), 64'd0);

        // Ack errors and asynchronous reset mid-traffic.
        send_ack(6'd9);
        check("t6_range_err", 64'(ack_err), 64'd1);
        check("t6_range_out", 64'(outstanding), 64'd0);
        dr_if.drtomem_req_retry   = 1'b1;
        dr_if.drtomem_pfreq_retry = 1'b1;
        for (int i = 0; i < 3; i++) push_dem(50'h4000 + 50'(i * 'h40), 3'd5);
        for (int i = 0; i < 3; i++) push_pf(50'h5000 + 50'(i * 'h40));
        check("t6_pre_req_valid", 64'(dr_if.drtomem_req_valid), 64'd1);
        check("t6_pre_pf_valid", 64'(dr_if.drtomem_pfreq_valid), 64'd1);
        base  = mq_paddr.size();
        pbase = pq_paddr.size();
        reset = 1'b1;
        #1;
        check("t6_rst_req_valid", 64'(dr_if.drtomem_req_valid), 64'd0);
        check("t6_rst_pf_valid", 64'(dr_if.drtomem_pfreq_valid), 64'd0);
        check("t6_rst_out", 64'(outstanding), 64'd0);
        check("t6_rst_err", 64'(ack_err), 64'd0);
        check("t6_rst_drop", 64'(pf_drop_cnt), 64'd0);
        dr_if.drtomem_req_retry   = 1'b0;
        dr_if.drtomem_pfreq_retry = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("t6_post_req_valid", 64'(dr_if.drtomem_req_valid), 64'd0);
        check("t6_post_pf_valid", 64'(dr_if.drtomem_pfreq_valid), 64'd0);
        check("t6_post_no_req", 64'(mq_paddr.size()), 64'(base));
        check("t6_post_no_pf", 64'(pq_paddr.size()), 64'(pbase));
        check("t6_post_retry", 64'(dr_if.l2todr_req_retry), 64'd0);
        send_ack(6'd5);
        check("t6_free_err", 64'(ack_err), 64'd1);
        check("t6_free_out", 64'(outstanding), 64'd0);
        repeat (3) tick();
        check("t6_sticky", 64'(ack_err), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
